result_trace_buffer: RTL and testbench
======================================

RESULT_TRACE_BUFFER -- requirements
Module: result_trace_buffer

Interface
REQ-001 The module SHALL have parameter WORDSIZE, default 64, the width of the traced result word.
REQ-002 The module SHALL have parameter DEPTH, default 16, the number of trace entries; it SHALL be a power of two and at least 2.
REQ-003 The module SHALL have parameter POST_TRIG, default 4, the number of samples stored after the trigger sample.
REQ-004 The module SHALL have parameter CHANGE_ONLY, default 0; when it is 1, only changed values are stored.
REQ-005 The module SHALL have port clk, input, 1 bit, the single clock; all logic updates on its rising edge.
REQ-006 The module SHALL have port reset, input, 1 bit, a synchronous active-high reset.
REQ-007 The module SHALL have port result, input, WORDSIZE bits, the processor result bus.
REQ-008 The module SHALL have port result_valid, input, 1 bit, which qualifies result on the current cycle.
REQ-009 The module SHALL have port arm, input, 1 bit, a one-cycle pulse that clears the buffer and starts capture.
REQ-010 The module SHALL have port trig_en, input, 1 bit, which enables trigger matching.
REQ-011 The module SHALL have port trig_value, input, WORDSIZE bits, the trigger compare value.
REQ-012 The module SHALL have port rd_valid, output, 1 bit, which indicates the oldest entry is available.
REQ-013 The module SHALL have port rd_data, output, WORDSIZE bits, carrying the oldest entry (first-word fall-through).
REQ-014 The module SHALL have port rd_ready, input, 1 bit; rd_valid and rd_ready both high pops one entry.
REQ-015 The module SHALL have port count, output, $clog2(DEPTH+1) bits, giving the number of stored entries.
REQ-016 The module SHALL have port state, output, 2 bits, giving the current state encoding.
REQ-017 The module SHALL have port overflow, output, 1 bit, a sticky flag set when an entry was overwritten.

Function
REQ-018 States SHALL be IDLE=0, CAPTURE=1, POST=2, FROZEN=3.
REQ-019 A sample SHALL be accepted when result_valid=1 in CAPTURE or POST.
- If CHANGE_ONLY=1, the sample SHALL additionally differ from the last accepted value.
- The first sample after arm SHALL always be accepted.
REQ-020 An accepted sample SHALL be written at the tail; count SHALL reflect it on the next cycle (latency 1).
REQ-021 When a sample is accepted with count==DEPTH, the oldest entry SHALL be overwritten, the head SHALL advance, count SHALL stay at DEPTH, and overflow SHALL be set.
REQ-022 Head and tail pointers SHALL wrap modulo DEPTH.
REQ-023 IDLE -> CAPTURE SHALL occur on arm.
REQ-024 CAPTURE SHALL detect a trigger when trig_en=1, result_valid=1 and result==trig_value.
- The trigger sample SHALL always be stored, bypassing the CHANGE_ONLY filter.
- The post counter SHALL load POST_TRIG.
- The next state SHALL be POST, or FROZEN if POST_TRIG==0.
REQ-025 In POST, each accepted sample SHALL decrement the post counter; the accepted sample that reaches zero SHALL be stored and the next state SHALL be FROZEN.
REQ-026 In FROZEN, no samples SHALL be stored and the trigger SHALL be ignored.
REQ-027 rd_valid SHALL equal (count!=0) in IDLE or FROZEN and SHALL be 0 in CAPTURE or POST.
REQ-028 A pop SHALL advance the head and decrement count on the next edge.
REQ-029 arm in any state SHALL clear count, pointers and overflow and enter CAPTURE; arm SHALL win over a simultaneous pop or sample, and neither SHALL take effect.
REQ-030 Trigger compare SHALL be full WORDSIZE equality; there SHALL be no masking.

Reset
REQ-031 When reset is high at a clock edge, the state SHALL be IDLE, count 0, pointers 0, overflow 0, rd_valid 0, and the post counter 0.
REQ-032 Reset SHALL take priority over arm; reset mid-capture SHALL discard all entries.
REQ-033 Buffer memory contents SHALL NOT require reset; rd_data SHALL be don't-care while rd_valid=0.

Configuration
REQ-034 With the macro RESULT_TRACE_TIMESTAMP_EN defined:
- Each entry SHALL additionally store a 32-bit cycle counter value.
- The counter SHALL clear on reset and arm, increment every cycle, and wrap at 2^32.
- The entry value SHALL be presented on an extra output rd_stamp, 32 bits, aligned with rd_data.
REQ-035 Without RESULT_TRACE_TIMESTAMP_EN, the rd_stamp port and the cycle counter SHALL be absent.

Structure
REQ-036 The state encoding constants and the default WORDSIZE SHALL reside in the shared package trace_pkg.
REQ-037 Storage SHALL be one sub-module, trace_ram: a DEPTH x WORDSIZE single-write, asynchronous-read array.

Verification
REQ-038 Overflow scenario: arm; then 20 consecutive valid samples 1..20 with trig_en=0 -> count=16, overflow=1, state stays CAPTURE.
REQ-039 Trigger scenario: arm; trig_value=7; samples 1..12 -> state FROZEN after sample 11; draining with rd_ready=1 yields 1..11, count=0.
REQ-040 CHANGE_ONLY=1 scenario: arm; samples 5,5,5,9,9,5 -> entries stored are 5,9,5.
REQ-041 POST_TRIG=0 scenario: trig_value=3; samples 1,2,3,4 -> state FROZEN the cycle after sample 3, count=3, and the last entry read is 3.
REQ-042 Simultaneous-event scenario: in FROZEN with count=4, arm and a pop in the same cycle -> next cycle count=0, state CAPTURE, overflow=0.
REQ-043 Reset scenario: reset asserted mid-POST -> next cycle state IDLE, count=0, rd_valid=0.

Source files
------------

// File: rtl/trace_pkg.sv
// Shared definitions for the result trace buffer: FSM state encoding,
// default traced word width and timestamp width.
package trace_pkg;

  localparam int TRACE_WORDSIZE_DEFAULT = 64;
  localparam int TRACE_STAMP_W          = 32;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_POST    = 2'd2,
    ST_FROZEN  = 2'd3
  } state_e;

endpackage

// File: rtl/trace_ram.sv
// Trace storage: DEPTH x WIDTH array, one synchronous write port and one
// asynchronous read port so the oldest entry falls through to the output.
// Contents are never reset.
module trace_ram #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 64
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [WIDTH-1:0]         wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [WIDTH-1:0]         rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Single write port; storage needs no reset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/result_trace_buffer.sv
// Result trace buffer: circular capture of the processor result bus with a
// value trigger, a configurable post-trigger window and a FIFO-style drain
// once frozen. Define RESULT_TRACE_TIMESTAMP_EN to store a 32-bit cycle
// stamp with every entry, presented on rd_stamp.
module result_trace_buffer
  import trace_pkg::*;
#(
  parameter int WORDSIZE    = TRACE_WORDSIZE_DEFAULT,
  parameter int DEPTH       = 16,
  parameter int POST_TRIG   = 4,
  parameter int CHANGE_ONLY = 0
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [WORDSIZE-1:0]          result,
  input  logic                         result_valid,
  input  logic                         arm,
  input  logic                         trig_en,
  input  logic [WORDSIZE-1:0]          trig_value,
  output logic                         rd_valid,
  output logic [WORDSIZE-1:0]          rd_data,
  input  logic                         rd_ready,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic [1:0]                   state,
  output logic                         overflow
`ifdef RESULT_TRACE_TIMESTAMP_EN
  ,
  output logic [TRACE_STAMP_W-1:0]     rd_stamp
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  // Post counter must hold POST_TRIG; keep at least one bit when it is 0.
  localparam int PW = (POST_TRIG < 1) ? 1 : $clog2(POST_TRIG + 1);

  state_e              state_q, state_d;
  logic [CW-1:0]       count_q, count_d;
  logic [AW-1:0]       head_q, head_d;
  logic [AW-1:0]       tail_q, tail_d;
  logic                overflow_q, overflow_d;
  logic [PW-1:0]       post_q, post_d;
  logic [WORDSIZE-1:0] last_q, last_d;
  logic                first_q, first_d;

  logic capturing;
  logic trig_hit;
  logic changed;
  logic accept;
  logic pop;
  logic full;
  logic wr_en;

  // Sample qualification: trigger samples bypass the change filter, and the
  // first sample after arm always counts as changed.
  always_comb begin
    capturing = (state_q == ST_CAPTURE) || (state_q == ST_POST);
    trig_hit  = (state_q == ST_CAPTURE) && trig_en && result_valid &&
                (result == trig_value);
    changed   = first_q || (result != last_q);
    accept    = capturing && result_valid &&
                (trig_hit || (CHANGE_ONLY == 0) || changed);
    pop       = rd_valid && rd_ready;
    full      = (count_q == CW'(DEPTH));
    wr_en     = accept && !arm;
  end

  // Next-state logic; arm overrides any sample or pop in the same cycle.
  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    head_d     = head_q;
    tail_d     = tail_q;
    overflow_d = overflow_q;
    post_d     = post_q;
    last_d     = last_q;
    first_d    = first_q;
    if (arm) begin
      state_d    = ST_CAPTURE;
      count_d    = '0;
      head_d     = '0;
      tail_d     = '0;
      overflow_d = 1'b0;
      post_d     = '0;
      first_d    = 1'b1;
    end else if (accept) begin
      tail_d  = tail_q + AW'(1);
      last_d  = result;
      first_d = 1'b0;
      if (full) begin
        // Overwrite the oldest entry: head follows tail, count saturates.
        head_d     = head_q + AW'(1);
        overflow_d = 1'b1;
      end else begin
        count_d = count_q + CW'(1);
      end
      if (trig_hit) begin
        post_d  = PW'(POST_TRIG);
        state_d = (POST_TRIG == 0) ? ST_FROZEN : ST_POST;
      end else if (state_q == ST_POST) begin
        post_d = post_q - PW'(1);
        if (post_q == PW'(1)) begin
          state_d = ST_FROZEN;
        end
      end
    end else if (pop) begin
      head_d  = head_q + AW'(1);
      count_d = count_q - CW'(1);
    end
  end

  // Control registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      count_q    <= '0;
      head_q     <= '0;
      tail_q     <= '0;
      overflow_q <= 1'b0;
      post_q     <= '0;
      last_q     <= '0;
      first_q    <= 1'b1;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      overflow_q <= overflow_d;
      post_q     <= post_d;
      last_q     <= last_d;
      first_q    <= first_d;
    end
  end

  // Entries may only be drained while capture is stopped.
  always_comb begin
    rd_valid = ((state_q == ST_IDLE) || (state_q == ST_FROZEN)) &&
               (count_q != '0);
  end

  assign count    = count_q;
  assign state    = state_q;
  assign overflow = overflow_q;

  trace_ram #(
    .DEPTH (DEPTH),
    .WIDTH (WORDSIZE)
  ) u_data_ram (
    .clk   (clk),
    .we    (wr_en),
    .waddr (tail_q),
    .wdata (result),
    .raddr (head_q),
    .rdata (rd_data)
  );

`ifdef RESULT_TRACE_TIMESTAMP_EN
  logic [TRACE_STAMP_W-1:0] stamp_q, stamp_d;

  // Free-running cycle stamp, restarted by arm; wraps naturally.
  always_comb begin
    stamp_d = arm ? '0 : stamp_q + TRACE_STAMP_W'(1);
  end

  // Stamp register with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      stamp_q <= '0;
    end else begin
      stamp_q <= stamp_d;
    end
  end

  trace_ram #(
    .DEPTH (DEPTH),
    .WIDTH (TRACE_STAMP_W)
  ) u_stamp_ram (
    .clk   (clk),
    .we    (wr_en),
    .waddr (tail_q),
    .wdata (stamp_q),
    .raddr (head_q),
    .rdata (rd_stamp)
  );
`endif

endmodule

// File: tb/tb_result_trace_buffer.sv
// Bench for result_trace_buffer: directed scenarios on three configurations
// (default, CHANGE_ONLY=1, POST_TRIG=0) plus a randomized run of the default
// configuration against a queue-based reference model.
module tb_result_trace_buffer;

  localparam int WS    = 64;
  localparam int DEPTH = 16;
  localparam int PT    = 4;

  logic          clk;
  logic          rst;
  logic [WS-1:0] result;
  logic          result_valid;
  logic          arm;
  logic          trig_en;
  logic [WS-1:0] trig_value;
  logic          rd_ready;

  logic          a_rd_valid, c_rd_valid, p_rd_valid;
  logic [WS-1:0] a_rd_data, c_rd_data, p_rd_data;
  logic [4:0]    a_count, c_count, p_count;
  logic [1:0]    a_state, c_state, p_state;
  logic          a_overflow, c_overflow, p_overflow;
`ifdef RESULT_TRACE_TIMESTAMP_EN
  logic [31:0]   a_stamp, c_stamp, p_stamp;
`endif

  int n_total = 0;
  int n_pass  = 0;

  // Reference model state (default configuration only)
  int            m_state;
  logic [WS-1:0] m_q[$];
  bit            m_ovf;
  int            m_post;
  logic [WS-1:0] m_last;
  bit            m_first;

  result_trace_buffer #(.WORDSIZE(WS), .DEPTH(DEPTH), .POST_TRIG(PT), .CHANGE_ONLY(0)) dut (
    .clk(clk), .reset(rst), .result(result), .result_valid(result_valid), .arm(arm),
    .trig_en(trig_en), .trig_value(trig_value), .rd_valid(a_rd_valid), .rd_data(a_rd_data),
    .rd_ready(rd_ready), .count(a_count), .state(a_state), .overflow(a_overflow)
`ifdef RESULT_TRACE_TIMESTAMP_EN
    , .rd_stamp(a_stamp)
`endif
  );

  result_trace_buffer #(.WORDSIZE(WS), .DEPTH(DEPTH), .POST_TRIG(PT), .CHANGE_ONLY(1)) dut_co (
    .clk(clk), .reset(rst), .result(result), .result_valid(result_valid), .arm(arm),
    .trig_en(trig_en), .trig_value(trig_value), .rd_valid(c_rd_valid), .rd_data(c_rd_data),
    .rd_ready(rd_ready), .count(c_count), .state(c_state), .overflow(c_overflow)
`ifdef RESULT_TRACE_TIMESTAMP_EN
    , .rd_stamp(c_stamp)
`endif
  );

  result_trace_buffer #(.WORDSIZE(WS), .DEPTH(DEPTH), .POST_TRIG(0), .CHANGE_ONLY(0)) dut_pt0 (
    .clk(clk), .reset(rst), .result(result), .result_valid(result_valid), .arm(arm),
    .trig_en(trig_en), .trig_value(trig_value), .rd_valid(p_rd_valid), .rd_data(p_rd_data),
    .rd_ready(rd_ready), .count(p_count), .state(p_state), .overflow(p_overflow)
`ifdef RESULT_TRACE_TIMESTAMP_EN
    , .rd_stamp(p_stamp)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model: buffer as a bounded queue, states as plain integers.
  task automatic model_step();
    bit hit;
    bit take;
    if (rst) begin
      m_state = 0; m_q.delete(); m_ovf = 0; m_post = 0; m_first = 1;
      return;
    end
    if (arm) begin
      m_state = 1; m_q.delete(); m_ovf = 0; m_post = 0; m_first = 1;
      return;
    end
    if ((m_state == 0 || m_state == 3) && m_q.size() != 0 && rd_ready) begin
      void'(m_q.pop_front());
    end else if ((m_state == 1 || m_state == 2) && result_valid) begin
      hit  = (m_state == 1) && trig_en && (result == trig_value);
      take = 1;  // change filter is off in this configuration
      if (take) begin
        if (m_q.size() == DEPTH) begin
          void'(m_q.pop_front());
          m_ovf = 1;
        end
        m_q.push_back(result);
        m_last  = result;
        m_first = 0;
        if (hit) begin
          m_post  = PT;
          m_state = (PT == 0) ? 3 : 2;
        end else if (m_state == 2) begin
          m_post--;
          if (m_post == 0) m_state = 3;
        end
      end
    end
  endtask

  // Advance one clock with the current inputs; outputs sampled 1 time unit after the edge.
  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    rst = 0; arm = 0; result_valid = 0; result = '0;
    trig_en = 0; trig_value = '0; rd_ready = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1;
    tick(); tick();
    rst = 0;
    n_total++; if (a_state !== 2'd0) $display("FAIL reset_state got %0d want 0", a_state); else n_pass++;
    n_total++; if (a_count !== 5'd0) $display("FAIL reset_count got %0d want 0", a_count); else n_pass++;
    n_total++; if (a_rd_valid !== 1'b0) $display("FAIL reset_rd_valid got %0b want 0", a_rd_valid); else n_pass++;
    n_total++; if (a_overflow !== 1'b0) $display("FAIL reset_overflow got %0b want 0", a_overflow); else n_pass++;
    n_total++; if (c_state !== 2'd0 || p_state !== 2'd0) $display("FAIL reset_state_cfg got %0d/%0d want 0/0", c_state, p_state); else n_pass++;
  endtask

  task automatic test_overflow();
    idle_inputs();
    arm = 1; tick(); arm = 0;
    n_total++; if (a_state !== 2'd1) $display("FAIL arm_state got %0d want 1", a_state); else n_pass++;
    for (int i = 1; i <= 20; i++) begin
      result_valid = 1; result = WS'(i); tick();
      if (i == 1) begin
        n_total++; if (a_count !== 5'd1) $display("FAIL first_count got %0d want 1", a_count); else n_pass++;
      end
    end
    result_valid = 0;
    n_total++; if (a_count !== 5'd16) $display("FAIL ovf_count got %0d want 16", a_count); else n_pass++;
    n_total++; if (a_overflow !== 1'b1) $display("FAIL ovf_flag got %0b want 1", a_overflow); else n_pass++;
    n_total++; if (a_state !== 2'd1) $display("FAIL ovf_state got %0d want 1", a_state); else n_pass++;
    n_total++; if (a_rd_valid !== 1'b0) $display("FAIL ovf_rd_valid got %0b want 0", a_rd_valid); else n_pass++;
  endtask

  task automatic test_trigger();
    idle_inputs();
    arm = 1; tick(); arm = 0;
    trig_en = 1; trig_value = WS'(7);
    for (int i = 1; i <= 12; i++) begin
      result_valid = 1; result = WS'(i); tick();
      if (i == 10) begin
        n_total++; if (a_state !== 2'd2) $display("FAIL trig_post_state got %0d want 2", a_state); else n_pass++;
      end
      if (i == 11) begin
        n_total++; if (a_state !== 2'd3) $display("FAIL trig_frozen_state got %0d want 3", a_state); else n_pass++;
      end
    end
    result_valid = 0; trig_en = 0;
    n_total++; if (a_count !== 5'd11) $display("FAIL trig_count got %0d want 11", a_count); else n_pass++;
    rd_ready = 1;
    for (int i = 1; i <= 11; i++) begin
      n_total++;
      if (a_rd_valid !== 1'b1 || a_rd_data !== WS'(i))
        $display("FAIL trig_drain[%0d] got v=%0b d=%0d want v=1 d=%0d", i, a_rd_valid, a_rd_data, i);
      else n_pass++;
      tick();
    end
    rd_ready = 0;
    n_total++; if (a_count !== 5'd0 || a_rd_valid !== 1'b0) $display("FAIL trig_drained got c=%0d v=%0b want c=0 v=0", a_count, a_rd_valid); else n_pass++;
  endtask

  task automatic test_change_only();
    logic [WS-1:0] seq [6] = '{5, 5, 5, 9, 9, 5};
    logic [WS-1:0] post [4] = '{6, 7, 8, 9};
    logic [WS-1:0] expv [8] = '{5, 9, 5, 5, 6, 7, 8, 9};
    idle_inputs();
    arm = 1; tick(); arm = 0;
    for (int i = 0; i < 6; i++) begin
      result_valid = 1; result = seq[i]; tick();
    end
    n_total++; if (c_count !== 5'd3) $display("FAIL co_count got %0d want 3", c_count); else n_pass++;
    // Trigger on a repeated value: stored despite the change filter.
    trig_en = 1; trig_value = WS'(5); result = WS'(5); tick();
    n_total++; if (c_count !== 5'd4) $display("FAIL co_trig_bypass got %0d want 4", c_count); else n_pass++;
    for (int i = 0; i < 4; i++) begin
      result = post[i]; tick();
    end
    result_valid = 0; trig_en = 0;
    n_total++; if (c_state !== 2'd3) $display("FAIL co_state got %0d want 3", c_state); else n_pass++;
    rd_ready = 1;
    for (int i = 0; i < 8; i++) begin
      n_total++;
      if (c_rd_valid !== 1'b1 || c_rd_data !== expv[i])
        $display("FAIL co_drain[%0d] got v=%0b d=%0d want v=1 d=%0d", i, c_rd_valid, c_rd_data, expv[i]);
      else n_pass++;
      tick();
    end
    rd_ready = 0;
  endtask

  task automatic test_post0();
    idle_inputs();
    arm = 1; tick(); arm = 0;
    trig_en = 1; trig_value = WS'(3);
    for (int i = 1; i <= 4; i++) begin
      result_valid = 1; result = WS'(i); tick();
      if (i == 2) begin
        n_total++; if (p_state !== 2'd1) $display("FAIL pt0_pre_state got %0d want 1", p_state); else n_pass++;
      end
      if (i == 3) begin
        n_total++; if (p_state !== 2'd3) $display("FAIL pt0_state got %0d want 3", p_state); else n_pass++;
      end
    end
    result_valid = 0; trig_en = 0;
    n_total++; if (p_count !== 5'd3) $display("FAIL pt0_count got %0d want 3", p_count); else n_pass++;
    rd_ready = 1;
    for (int i = 1; i <= 3; i++) begin
      n_total++;
      if (p_rd_valid !== 1'b1 || p_rd_data !== WS'(i))
        $display("FAIL pt0_drain[%0d] got v=%0b d=%0d want v=1 d=%0d", i, p_rd_valid, p_rd_data, i);
      else n_pass++;
      tick();
    end
    rd_ready = 0;
  endtask

  task automatic test_simultaneous();
    idle_inputs();
    arm = 1; tick(); arm = 0;
    for (int i = 1; i <= 20; i++) begin
      result_valid = 1; result = WS'(i); tick();
    end
    trig_en = 1; trig_value = WS'(100);
    for (int i = 100; i <= 104; i++) begin
      result = WS'(i); tick();
    end
    result_valid = 0; trig_en = 0;
    n_total++; if (a_state !== 2'd3 || a_overflow !== 1'b1) $display("FAIL sim_frozen got s=%0d o=%0b want s=3 o=1", a_state, a_overflow); else n_pass++;
    rd_ready = 1;
    for (int i = 0; i < 12; i++) tick();
    n_total++; if (a_count !== 5'd4) $display("FAIL sim_count4 got %0d want 4", a_count); else n_pass++;
    arm = 1; tick();
    arm = 0; rd_ready = 0;
    n_total++; if (a_count !== 5'd0) $display("FAIL sim_arm_count got %0d want 0", a_count); else n_pass++;
    n_total++; if (a_state !== 2'd1) $display("FAIL sim_arm_state got %0d want 1", a_state); else n_pass++;
    n_total++; if (a_overflow !== 1'b0) $display("FAIL sim_arm_overflow got %0b want 0", a_overflow); else n_pass++;
  endtask

  task automatic test_reset_mid_post();
    idle_inputs();
    arm = 1; tick(); arm = 0;
    trig_en = 1; trig_value = WS'(7);
    for (int i = 1; i <= 8; i++) begin
      result_valid = 1; result = WS'(i); tick();
    end
    n_total++; if (a_state !== 2'd2) $display("FAIL rst_pre_state got %0d want 2", a_state); else n_pass++;
    rst = 1; arm = 1; result = WS'(9); tick();
    idle_inputs();
    n_total++; if (a_state !== 2'd0) $display("FAIL rst_post_state got %0d want 0", a_state); else n_pass++;
    n_total++; if (a_count !== 5'd0) $display("FAIL rst_post_count got %0d want 0", a_count); else n_pass++;
    n_total++; if (a_rd_valid !== 1'b0) $display("FAIL rst_post_rd_valid got %0b want 0", a_rd_valid); else n_pass++;
  endtask

  task automatic test_random();
    bit exp_rv;
    for (int cyc = 0; cyc < 600; cyc++) begin
      rst          = ($urandom_range(0, 99) < 2);
      arm          = ($urandom_range(0, 99) < 4);
      result_valid = ($urandom_range(0, 9) < 7);
      result       = WS'($urandom_range(0, 7));
      result[WS-1] = ($urandom_range(0, 9) == 0);
      trig_en      = ($urandom_range(0, 9) < 4);
      trig_value   = WS'($urandom_range(0, 7));
      rd_ready     = $urandom_range(0, 1);
      tick();
      exp_rv = (m_state == 0 || m_state == 3) && (m_q.size() != 0);
      n_total++;
      if (a_state !== 2'(m_state) || a_count !== 5'(m_q.size()) ||
          a_overflow !== m_ovf || a_rd_valid !== exp_rv)
        $display("FAIL rand[%0d] got s=%0d c=%0d o=%0b v=%0b want s=%0d c=%0d o=%0b v=%0b",
                 cyc, a_state, a_count, a_overflow, a_rd_valid, m_state, m_q.size(), m_ovf, exp_rv);
      else n_pass++;
      if (exp_rv) begin
        n_total++;
        if (a_rd_data !== m_q[0])
          $display("FAIL rand_data[%0d] got %0h want %0h", cyc, a_rd_data, m_q[0]);
        else n_pass++;
      end
    end
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    m_state = 0; m_ovf = 0; m_post = 0; m_last = '0; m_first = 1;
    test_reset();
    test_overflow();
    test_trigger();
    test_change_only();
    test_post0();
    test_simultaneous();
    test_reset_mid_post();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
